// File: rtl/norm_pkg.sv
// norm_pkg: shared widths and FSM encoding for the sequential normaliser.
package norm_pkg;
  localparam int NORM_WIDTH = 16;
  localparam int NORM_STEPS = $clog2(NORM_WIDTH);
  localparam int NORM_SHW = $clog2(NORM_WIDTH) + 1;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
endpackage

// File: rtl/norm_step.sv
// norm_step: one binary-search stage; shifts by step when the step bits at the justified end are all zero.
module norm_step #(
  parameter int WIDTH = 16,
  parameter int SHW = 5
) (
  input  logic [WIDTH-1:0] work,
  input  logic [SHW-1:0]   step,
  input  logic             right,
  output logic [WIDTH-1:0] work_nxt,
  output logic             hit
);
  always_comb begin
    hit = right ? ((work << (WIDTH - int'(step))) == '0) : ((work >> (WIDTH - int'(step))) == '0);
    work_nxt = hit ? (right ? work >> step : work << step) : work;
  end
endmodule

// File: rtl/normalize_shifter_seq.sv
// normalize_shifter_seq: multi-cycle leading/trailing-zero normaliser with valid/ready handshakes.
module normalize_shifter_seq
  import norm_pkg::*;
#(
  parameter int WIDTH = NORM_WIDTH,
  parameter int STEPS = $clog2(WIDTH),
  parameter int SHW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_right,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_shift,
  output logic             out_zero
);
  localparam int IW = $clog2(STEPS);
  state_e state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d, work_nxt, out_data_q, out_data_d;
  logic [SHW-1:0] cnt_q, cnt_d, out_shift_q, out_shift_d, step;
  logic [IW-1:0] idx_q, idx_d;
  logic right_q, right_d, zero_q, zero_d, hit;
  logic out_valid_q, out_valid_d, out_zero_q, out_zero_d;
  assign step = SHW'(WIDTH >> (32'(idx_q) + 1));
  norm_step #(.WIDTH(WIDTH), .SHW(SHW)) u_step (
    .work(work_q), .step(step), .right(right_q), .work_nxt(work_nxt), .hit(hit)
  );
  always_comb begin
    state_d = state_q;
    work_d = work_q;
    right_d = right_q;
    zero_d = zero_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    out_shift_d = out_shift_q;
    out_zero_d = out_zero_q;
    if (state_q == ST_IDLE && in_valid) begin
      state_d = ST_RUN;
      work_d = in_data;
      right_d = in_right;
      zero_d = in_data == '0;
      cnt_d = '0;
      idx_d = '0;
    end
    if (state_q == ST_RUN) begin
      work_d = work_nxt;
      cnt_d = cnt_q + (hit ? step : '0);
      idx_d = idx_q + IW'(1);
      if (idx_q == IW'(STEPS - 1)) begin
        state_d = ST_DONE;
        out_valid_d = 1'b1;
        out_data_d = zero_q ? '0 : work_nxt;
        out_shift_d = zero_q ? SHW'(WIDTH) : cnt_d;
        out_zero_d = zero_q;
      end
    end
    if (state_q == ST_DONE && out_ready) begin
      state_d = ST_IDLE;
      out_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      work_q <= '0;
      right_q <= 1'b0;
      zero_q <= 1'b0;
      cnt_q <= '0;
      idx_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_shift_q <= '0;
      out_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q <= work_d;
      right_q <= right_d;
      zero_q <= zero_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_shift_q <= out_shift_d;
      out_zero_q <= out_zero_d;
    end
  end
  assign in_ready = state_q == ST_IDLE;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_shift = out_shift_q;
  assign out_zero = out_zero_q;
endmodule
